// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// Sends one command byte from the host to a PS/2 device, for example an LED
// command. The host holds the clock line low (inhibit) and drives the start bit.
// It then shifts out data[0..7], odd parity and the stop bit on the falling
// edges that the device generates. Finally it samples the device ACK and waits
// for both lines to go idle.
//
// Ports
//   clk           system clock, all logic on rising edge
//   reset         synchronous, active-high
//   data[7:0]     byte to send, taken when valid && ready
//   valid         byte on data is valid
//   ready         block can accept a byte
//   ps2_clk       raw PS/2 clock line (asynchronous)
//   ps2_data      raw PS/2 data line (asynchronous)
//   ps2_clk_low   1 = pull PS/2 clock low (open drain)
//   ps2_data_low  1 = pull PS/2 data low (open drain)
//   busy          transfer in progress (hold the PS/2 receiver idle)
//   done          one-cycle pulse: byte acknowledged by the device
//   error         one-cycle pulse: NACK or timeout
// -----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2600,
    parameter int unsigned TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, RELEASE} state_t;

    state_t           state;
    logic [7:0]       data_q;
    logic             parity_q;
    logic [3:0]       bit_idx;
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;

    // Two-flop synchronizers. They reset to 1 (the idle bus level) so that
    // leaving reset cannot fake a falling edge.
    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic clk_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    assign clk_fall = clk_prev & ~clk_sync;

    // Frame bits presented after each device falling edge; the stop bit is
    // 1, which means the data line is released.
    logic [9:0] frame;
    assign frame = {1'b1, parity_q, data_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ready        <= 1'b1;
            busy         <= 1'b0;
            ps2_clk_low  <= 1'b0;
            ps2_data_low <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            data_q       <= 8'h00;
            parity_q     <= 1'b0;
            bit_idx      <= 4'd0;
            inh_cnt      <= '0;
            to_cnt       <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid && ready) begin
                        data_q       <= data;
                        parity_q     <= ~^data;
                        inh_cnt      <= '0;
                        ready        <= 1'b0;
                        busy         <= 1'b1;
                        ps2_clk_low  <= 1'b1;
                        ps2_data_low <= 1'b0;
                        state        <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_data_low <= 1'b1;  // start bit
                        ps2_clk_low  <= 1'b0;
                        bit_idx      <= 4'd0;
                        to_cnt       <= '0;
                        state        <= SEND;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                SEND, ACK, RELEASE: begin
                    if (to_cnt == TO_LAST) begin
                        ps2_clk_low  <= 1'b0;
                        ps2_data_low <= 1'b0;
                        error        <= 1'b1;
                        ready        <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (state == SEND) begin
                            if (clk_fall) begin
                                ps2_data_low <= ~frame[bit_idx];
                                bit_idx      <= bit_idx + 4'd1;
                                if (bit_idx == 4'd9) begin
                                    state <= ACK;
                                end
                            end
                        end else if (state == ACK) begin
                            if (clk_fall) begin
                                if (!data_sync) begin
                                    state <= RELEASE;
                                end else begin
                                    ps2_data_low <= 1'b0;
                                    error        <= 1'b1;
                                    ready        <= 1'b1;
                                    busy         <= 1'b0;
                                    state        <= IDLE;
                                end
                            end
                        end else if (clk_sync && data_sync) begin
                            done  <= 1'b1;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    ps2_clk_low  <= 1'b0;
                    ps2_data_low <= 1'b0;
                    ready        <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
// Drives ps2_host_tx against a behavioural PS/2 device on an open-drain bus.
// Expected frames are pushed when a byte is offered. Frames captured by the
// device are popped and compared against them.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int unsigned INH  = 50;
    localparam int unsigned TO   = 1000;
    localparam int          HALF = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready, ps2_clk_low, ps2_data_low, busy, done, error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data;

    assign ps2_clk  = ~(ps2_clk_low | dev_clk_low);
    assign ps2_data = ~(ps2_data_low | dev_data_low);

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int done_not_ready = 0;
    int inh_len = 0;
    logic [9:0] exp_q[$];
    logic [9:0] rx_q[$];

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .valid        (valid),
        .ready        (ready),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .ps2_clk_low  (ps2_clk_low),
        .ps2_data_low (ps2_data_low),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
        if (done === 1'b1 && ready !== 1'b1) done_not_ready++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one byte; optionally push the frame the device should receive.
    task automatic send_byte(input logic [7:0] b, input bit expect_frame);
        int n = 0;
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (ready !== 1'b1) begin
            fails++;
            $display("FAIL send_ready: ready=%b, required 1", ready);
        end
        data  = b;
        valid = 1'b1;
        if (expect_frame) exp_q.push_back({1'b1, ~^b, b});
        @(negedge clk);
        valid = 1'b0;
        tests++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL accept: ready=%b busy=%b, required 0/1", ready, busy);
        end
    endtask

    // Device model: mode 0 = ACK, 1 = NACK (data held high), 2 = never clocks.
    // stop_after > 0 abandons the frame after that many clock pulses.
    task automatic device_run(input int mode, input int stop_after);
        int n;
        logic [9:0] bits;
        bits = '0;
        n = 0;
        while (ps2_clk_low !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (ps2_clk_low !== 1'b1) begin
            fails++;
            $display("FAIL inhibit_start: ps2_clk_low=%b, required 1", ps2_clk_low);
            return;
        end
        n = 0;
        while (ps2_clk_low === 1'b1 && n < 4 * INH) begin
            @(negedge clk);
            n++;
        end
        inh_len = n;
        tests++;
        if (n < INH || ps2_clk_low !== 1'b0) begin
            fails++;
            $display("FAIL inhibit_len: held %0d cycles, required >= %0d", n, INH);
        end
        tests++;
        if (ps2_data_low !== 1'b1) begin
            fails++;
            $display("FAIL start_bit: ps2_data_low=%b, required 1", ps2_data_low);
        end
        if (mode == 2) return;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
            if (k <= 10) bits[k-1] = ps2_data;
            if (k == stop_after) return;
            if (k == 10 && mode == 0) dev_data_low = 1'b1;
            if (k == 11) dev_data_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
        end
        rx_q.push_back(bits);
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = (ready === 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (ready !== 1'b1 || busy !== 1'b0 || ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0 ||
            done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b busy=%b cl=%b dl=%b done=%b err=%b, required 100000",
                     ready, busy, ps2_clk_low, ps2_data_low, done, error);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_send_ed();
        int d0 = done_cnt;
        int e0 = err_cnt;
        bit ok;
        logic [9:0] got, want;
        send_byte(8'hED, 1'b1);
        device_run(0, 0);
        wait_ready(ok);
        tests++;
        if (!ok || busy !== 1'b0 || ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0) begin
            fails++;
            $display("FAIL ed_idle: rdy=%b busy=%b cl=%b dl=%b, required 1000",
                     ready, busy, ps2_clk_low, ps2_data_low);
        end
        tests++;
        if (rx_q.size() != 1) begin
            fails++;
            $display("FAIL ed_frames: got %0d frames, required 1", rx_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            tests++;
            if (got !== want || got !== 10'h3ED) begin
                fails++;
                $display("FAIL ed_frame: got %h, required %h", got, want);
            end
        end
        exp_q.delete();
        rx_q.delete();
        tests++;
        if (done_cnt != d0 + 1 || err_cnt != e0) begin
            fails++;
            $display("FAIL ed_pulses: done=%0d err=%0d, required 1/0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int e0 = err_cnt;
        bit ok;
        logic [9:0] got, want;
        send_byte(8'h00, 1'b1);
        device_run(0, 0);
        send_byte(8'h01, 1'b1);
        device_run(0, 0);
        wait_ready(ok);
        tests++;
        if (rx_q.size() != 2) begin
            fails++;
            $display("FAIL b2b_frames: got %0d frames, required 2", rx_q.size());
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL b2b_frame: got %h, required %h", got, want);
            end
        end
        exp_q.delete();
        rx_q.delete();
        tests++;
        if (done_cnt != d0 + 2 || err_cnt != e0 || !ok) begin
            fails++;
            $display("FAIL b2b_pulses: done=%0d err=%0d, required 2/0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_nack();
        int d0 = done_cnt;
        int e0 = err_cnt;
        bit ok;
        logic [9:0] got, want;
        send_byte(8'h3C, 1'b1);
        device_run(1, 0);
        wait_ready(ok);
        tests++;
        if (err_cnt != e0 + 1 || done_cnt != d0) begin
            fails++;
            $display("FAIL nack_pulses: done=%0d err=%0d, required 0/1", done_cnt - d0, err_cnt - e0);
        end
        tests++;
        if (!ok || busy !== 1'b0 || ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0) begin
            fails++;
            $display("FAIL nack_idle: rdy=%b busy=%b cl=%b dl=%b, required 1000",
                     ready, busy, ps2_clk_low, ps2_data_low);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL nack_frame: got %h, required %h", got, want);
            end
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_timeout();
        int e0 = err_cnt;
        int d0 = done_cnt;
        int c = 0;
        send_byte(8'h5A, 1'b0);
        device_run(2, 0);
        while (error !== 1'b1 && c < 2 * TO) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (c != TO) begin
            fails++;
            $display("FAIL timeout_len: error after %0d cycles, required %0d", c, TO);
        end
        tests++;
        if (ps2_data_low !== 1'b0 || ps2_clk_low !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL timeout_lines: dl=%b cl=%b rdy=%b, required 0/0/1",
                     ps2_data_low, ps2_clk_low, ready);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (err_cnt != e0 + 1 || done_cnt != d0) begin
            fails++;
            $display("FAIL timeout_pulses: done=%0d err=%0d, required 0/1",
                     done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_ignore_valid();
        int d0 = done_cnt;
        bit ok;
        logic [9:0] got, want;
        send_byte(8'hED, 1'b1);
        fork
            device_run(0, 0);
            begin
                int n = 0;
                while (ps2_clk_low === 1'b1 && n < 4 * INH) begin
                    @(negedge clk);
                    n++;
                end
                repeat (60) @(negedge clk);
                data  = 8'h55;
                valid = 1'b1;
                tests++;
                if (ready !== 1'b0) begin
                    fails++;
                    $display("FAIL ignore_ready: ready=%b during SEND, required 0", ready);
                end
                @(negedge clk);
                valid = 1'b0;
            end
        join
        wait_ready(ok);
        tests++;
        if (rx_q.size() != 1 || done_cnt != d0 + 1 || !ok) begin
            fails++;
            $display("FAIL ignore_count: frames=%0d done=%0d, required 1/1",
                     rx_q.size(), done_cnt - d0);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL ignore_frame: got %h, required %h", got, want);
            end
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_reset_mid();
        int d0 = done_cnt;
        int e0 = err_cnt;
        bit ok;
        logic [9:0] got, want;
        send_byte(8'hA5, 1'b0);
        device_run(0, 4);
        // bit 3 of 0xA5 is 0, so the data line should be pulled low here
        tests++;
        if (ps2_data_low !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL mid_bit3: dl=%b busy=%b, required 1/1", ps2_data_low, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: cl=%b dl=%b rdy=%b busy=%b, required 0/0/1/0",
                     ps2_clk_low, ps2_data_low, ready, busy);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (done_cnt != d0 || err_cnt != e0) begin
            fails++;
            $display("FAIL mid_pulses: done=%0d err=%0d, required 0/0", done_cnt - d0, err_cnt - e0);
        end
        send_byte(8'hF4, 1'b1);
        device_run(0, 0);
        wait_ready(ok);
        tests++;
        if (rx_q.size() != 1 || done_cnt != d0 + 1 || err_cnt != e0 || !ok) begin
            fails++;
            $display("FAIL f4_count: frames=%0d done=%0d err=%0d, required 1/1/0",
                     rx_q.size(), done_cnt - d0, err_cnt - e0);
        end
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL f4_frame: got %h, required %h", got, want);
            end
        end
        exp_q.delete();
        rx_q.delete();
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_back_to_back();
        test_nack();
        test_timeout();
        test_ignore_valid();
        test_reset_mid();
        tests++;
        if (both_cnt != 0 || done_not_ready != 0) begin
            fails++;
            $display("FAIL pulse_rules: done&error=%0d done&!ready=%0d, required 0/0",
                     both_cnt, done_not_ready);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
